alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul.sv | 41 ++++
 rtl/alu.sv | 102 ++++++++++
 tb/tb_alu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the ALU slice.
//   alu_cmd_e : 4-bit operation select carried on alu.command
//   ALU_SIZE  : default operand width in bits
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned ALU_SIZE = 4;

    typedef enum logic [3:0] {
        CMD_AND  = 4'h0,
        CMD_OR   = 4'h1,
        CMD_XOR  = 4'h2,
        CMD_NOT  = 4'h3,
        CMD_ADDU = 4'h4,
        CMD_ADDS = 4'h5,
        CMD_SUBU = 4'h6,
        CMD_SUBS = 4'h7,
        CMD_MULU = 4'h8,
        CMD_MULS = 4'h9
    } alu_cmd_e;

endpackage

// File: rtl/alu_mul.sv
// ---------------------------------------------------------------------------
// alu_mul -- combinational SIZE x SIZE multiplier with overflow detection.
//   signed_mode : 1 = two's-complement operands, 0 = unsigned operands
//   a, b        : SIZE-bit operands
//   product     : 2*SIZE-bit product
//   overflow    : product does not fit in SIZE bits (signed or unsigned range)
// ---------------------------------------------------------------------------
module alu_mul #(
    parameter int unsigned SIZE = alu_pkg::ALU_SIZE
) (
    input  logic                signed_mode,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    output logic [2*SIZE-1:0]   product,
    output logic                overflow
);

    logic [2*SIZE-1:0] a_ext;
    logic [2*SIZE-1:0] b_ext;
    logic [SIZE:0]     p_top;

    // A single multiplier serves both modes: operands are sign- or
    // zero-extended to 2*SIZE bits and the product truncated to 2*SIZE,
    // which is exact modulo 2^(2*SIZE) in either interpretation.
    assign a_ext   = {{SIZE{signed_mode & a[SIZE-1]}}, a};
    assign b_ext   = {{SIZE{signed_mode & b[SIZE-1]}}, b};
    assign product = a_ext * b_ext;

    // Signed fit: bits [2*SIZE-1:SIZE-1] are all copies of the sign.
    assign p_top = product[2*SIZE-1:SIZE-1];

    always_comb begin
        overflow = 1'b0;
        if (signed_mode) begin
            overflow = !((&p_top) || (~|p_top));
        end else begin
            overflow = |product[2*SIZE-1:SIZE];
        end
    end

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered arithmetic/logic unit, one cycle latency.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears result and overflow
//   enable   : capture the current operation on this edge; else hold
//   command  : operation select (alu_pkg::alu_cmd_e), 0xA-0xF give zero
//   a, b     : SIZE-bit operands
//   overflow : registered overflow flag
//   result   : registered 2*SIZE-bit result
// Configuration: define ALU_MUL_EN to build the multiplier (commands 0x8,
// 0x9); without it those commands return zero and no multiplier exists.
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int unsigned SIZE = ALU_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [3:0]          command,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    output logic                overflow,
    output logic [2*SIZE-1:0]   result
);

    localparam int unsigned MSB = SIZE - 1;

    logic [SIZE:0]       sum;
    logic [SIZE-1:0]     diff;
    logic [2*SIZE-1:0]   result_d;
    logic                overflow_d;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = a - b;

`ifdef ALU_MUL_EN
    logic [2*SIZE-1:0]   mul_p;
    logic                mul_ovf;

    alu_mul #(
        .SIZE (SIZE)
    ) u_mul (
        .signed_mode (command == CMD_MULS),
        .a           (a),
        .b           (b),
        .product     (mul_p),
        .overflow    (mul_ovf)
    );
`endif

    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        case (alu_cmd_e'(command))
            CMD_AND:  result_d = {{SIZE{1'b0}}, a & b};
            CMD_OR:   result_d = {{SIZE{1'b0}}, a | b};
            CMD_XOR:  result_d = {{SIZE{1'b0}}, a ^ b};
            CMD_NOT:  result_d = {{SIZE{1'b0}}, ~a};
            CMD_ADDU: begin
                result_d   = {{SIZE{1'b0}}, sum[SIZE-1:0]};
                overflow_d = sum[SIZE];
            end
            CMD_ADDS: begin
                result_d   = {{SIZE{1'b0}}, sum[SIZE-1:0]};
                overflow_d = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            CMD_SUBU: result_d = {{SIZE{1'b0}}, diff};
            CMD_SUBS: begin
                result_d   = {{SIZE{1'b0}}, diff};
                overflow_d = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
`ifdef ALU_MUL_EN
            CMD_MULU: begin
                // Top result bit is forced low for the unsigned product.
                result_d   = {1'b0, mul_p[2*SIZE-2:0]};
                overflow_d = mul_ovf;
            end
            CMD_MULS: begin
                result_d   = {{SIZE{1'b0}}, mul_p[SIZE-1:0]};
                overflow_d = mul_ovf;
            end
`endif
            default: begin
                result_d   = '0;
                overflow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
        end else if (enable) begin
            result   <= result_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (SIZE=4): directed vectors, hold,
// asynchronous reset and randomized operations against a reference model.
// Multiply expectations follow ALU_MUL_EN.
// ---------------------------------------------------------------------------
module tb_alu;

    localparam int S = 4;
    localparam longint M = 64'sd1 << S;
    localparam longint H = 64'sd1 << (S - 1);

    logic           clk;
    logic           rst_n;
    logic           enable;
    logic [3:0]     command;
    logic [S-1:0]   a;
    logic [S-1:0]   b;
    logic           overflow;
    logic [2*S-1:0] result;

    int errors = 0;
    int checks = 0;

    logic [2*S-1:0] exp_res;
    logic           exp_ovf;

    alu #(
        .SIZE (S)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .command  (command),
        .a        (a),
        .b        (b),
        .overflow (overflow),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint to_signed(input longint v);
        return (v >= H) ? v - M : v;
    endfunction

    function automatic bit out_of_range(input longint v);
        return (v < -H) || (v > H - 1);
    endfunction

    // Reference: returns {overflow, result} computed with plain integer math.
    function automatic logic [2*S:0] model(input int cmd, input longint ua, input longint ub);
        longint sa, sb, r, p;
        bit     o;
        sa = to_signed(ua);
        sb = to_signed(ub);
        r  = 0;
        o  = 1'b0;
        case (cmd)
            0: r = ua & ub;
            1: r = ua | ub;
            2: r = ua ^ ub;
            3: r = (M - 1) - ua;
            4: begin r = (ua + ub) % M; o = (ua + ub) >= M; end
            5: begin r = (ua + ub) % M; o = out_of_range(sa + sb); end
            6: r = (ua - ub + M) % M;
            7: begin r = (ua - ub + M) % M; o = out_of_range(sa - sb); end
`ifdef ALU_MUL_EN
            8: begin p = ua * ub; r = p % (M * H); o = p >= M; end
            9: begin p = sa * sb; r = ((p % M) + M) % M; o = out_of_range(p); end
`endif
            default: begin r = 0; o = 1'b0; end
        endcase
        return {o, r[2*S-1:0]};
    endfunction

    task automatic step(input int cmd, input int va, input int vb, input bit en);
        @(negedge clk);
        command = cmd[3:0];
        a       = va[S-1:0];
        b       = vb[S-1:0];
        enable  = en;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int cmd; int a; int b; int res; int ovf;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [2*S:0] m;

        rst_n   = 1'b0;
        enable  = 1'b0;
        command = '0;
        a       = '0;
        b       = '0;

        // Reset state, clock running
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 0);
        check("reset_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs = '{
            '{cmd: 4'h0, a: 7,   b: 3,   res: 8'h03, ovf: 0},
            '{cmd: 4'h2, a: 'hA, b: 5,   res: 8'h0F, ovf: 0},
            '{cmd: 4'h3, a: 7,   b: 'hC, res: 8'h08, ovf: 0},
            '{cmd: 4'h4, a: 'hF, b: 1,   res: 8'h00, ovf: 1},
            '{cmd: 4'h5, a: 7,   b: 1,   res: 8'h08, ovf: 1},
            '{cmd: 4'h5, a: 8,   b: 'hF, res: 8'h07, ovf: 1},
            '{cmd: 4'h5, a: 'hF, b: 1,   res: 8'h00, ovf: 0},
            '{cmd: 4'h6, a: 0,   b: 1,   res: 8'h0F, ovf: 0},
            '{cmd: 4'h7, a: 0,   b: 7,   res: 8'h09, ovf: 0},
            '{cmd: 4'h7, a: 'hF, b: 1,   res: 8'h0E, ovf: 0},
`ifdef ALU_MUL_EN
            '{cmd: 4'h8, a: 'hF, b: 'hF, res: 8'h61, ovf: 1},
            '{cmd: 4'h8, a: 7,   b: 8,   res: 8'h38, ovf: 1},
            '{cmd: 4'h9, a: 'hF, b: 2,   res: 8'h0E, ovf: 0},
            '{cmd: 4'h9, a: 'hE, b: 'hB, res: 8'h0A, ovf: 1},
`else
            '{cmd: 4'h8, a: 'hF, b: 'hF, res: 8'h00, ovf: 0},
            '{cmd: 4'h9, a: 'hE, b: 'hB, res: 8'h00, ovf: 0},
`endif
            '{cmd: 4'hC, a: 'hF, b: 'hF, res: 8'h00, ovf: 0}
        };

        foreach (vecs[i]) begin
            step(vecs[i].cmd, vecs[i].a, vecs[i].b, 1'b1);
            check($sformatf("dir%0d_cmd%0h_res", i, vecs[i].cmd), result, vecs[i].res);
            check($sformatf("dir%0d_cmd%0h_ovf", i, vecs[i].cmd), overflow, vecs[i].ovf);
        end

        // Hold with enable low: load a nonzero result with overflow set
        step(4'h5, 7, 1, 1'b1);
        check("hold_load_res", result, 8'h08);
        check("hold_load_ovf", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            step(i * 2, 'hF - i, i, 1'b0);
            check($sformatf("hold%0d_res", i), result, 8'h08);
            check($sformatf("hold%0d_ovf", i), overflow, 1);
        end

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_res", result, 0);
        check("async_rst_ovf", overflow, 0);
        @(posedge clk);
        #1;
        check("rst_held_res", result, 0);
        #2;
        rst_n = 1'b1;

        // First capture only at an enabled edge after release
        step(4'h3, 0, 0, 1'b0);
        check("post_rst_noen_res", result, 0);
        step(4'h3, 0, 0, 1'b1);
        check("post_rst_cap_res", result, 8'h0F);
        check("post_rst_cap_ovf", overflow, 0);

        // Randomized operations with random enable
        exp_res = result;
        exp_ovf = overflow;
        for (int i = 0; i < 400; i++) begin
            int  c, va, vb;
            bit  en;
            c  = $urandom_range(0, 15);
            va = $urandom_range(0, 15);
            vb = $urandom_range(0, 15);
            en = ($urandom_range(0, 3) != 0);
            step(c, va, vb, en);
            if (en) begin
                m       = model(c, va, vb);
                exp_res = m[2*S-1:0];
                exp_ovf = m[2*S];
            end
            check($sformatf("rnd%0d_cmd%0h_a%0h_b%0h_res", i, c, va, vb), result, exp_res);
            check($sformatf("rnd%0d_cmd%0h_a%0h_b%0h_ovf", i, c, va, vb), overflow, exp_ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
